// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Two-requester writeback arbiter for the register file write port
//            with a pending-write scoreboard that stalls decode on RAW/WAW.
// Options  : REGARB_FIXED_PRIO_EN - requester B always wins, no RR pointer.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          A_Valid,
  input  logic [AW-1:0] A_Adr,
  input  logic [DW-1:0] A_Din,
  output logic          A_Ready,
  input  logic          B_Valid,
  input  logic [AW-1:0] B_Adr,
  input  logic [DW-1:0] B_Din,
  output logic          B_Ready,
  output logic          WE,
  output logic [AW-1:0] WAdr,
  output logic [DW-1:0] Din,
  input  logic          Iss_Valid,
  input  logic [AW-1:0] Iss_Adr,
  input  logic [AW-1:0] Chk1Adr,
  input  logic [AW-1:0] Chk2Adr,
  output logic          Stall
);

  localparam int c_NREG = 1 << AW;

  logic [c_NREG-1:0] r_pending;
  logic [c_NREG-1:0] w_pend_nxt;
  logic              w_b_wins;
  logic              w_hz1;
  logic              w_hz2;
  logic              w_hz_iss;
  logic              w_set;

`ifdef REGARB_FIXED_PRIO_EN
  assign w_b_wins = 1'b1;
`else
  // Round-robin pointer: 0 = A has priority, 1 = B has priority.
  logic r_ptr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ptr <= 1'b0;
    end else if (A_Ready) begin
      r_ptr <= 1'b1;
    end else if (B_Ready) begin
      r_ptr <= 1'b0;
    end
  end

  assign w_b_wins = r_ptr;
`endif

  assign A_Ready = Rst_n & A_Valid & (~B_Valid | ~w_b_wins);
  assign B_Ready = Rst_n & B_Valid & (~A_Valid |  w_b_wins);

  // Address 0 is accepted but never written.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WE   <= 1'b0;
      WAdr <= '0;
      Din  <= '0;
    end else if (A_Ready) begin
      WE   <= (A_Adr != '0);
      WAdr <= A_Adr;
      Din  <= A_Din;
    end else if (B_Ready) begin
      WE   <= (B_Adr != '0);
      WAdr <= B_Adr;
      Din  <= B_Din;
    end else begin
      WE   <= 1'b0;
    end
  end

  // The register on the write port this cycle is readable before the next
  // posedge thanks to the negedge write, so it is not treated as a hazard.
  assign w_hz1    = r_pending[Chk1Adr] & ~(WE & (WAdr == Chk1Adr)) & (Chk1Adr != '0);
  assign w_hz2    = r_pending[Chk2Adr] & ~(WE & (WAdr == Chk2Adr)) & (Chk2Adr != '0);
  assign w_hz_iss = r_pending[Iss_Adr] & ~(WE & (WAdr == Iss_Adr)) & (Iss_Adr != '0);

  assign Stall = Iss_Valid & (w_hz1 | w_hz2 | w_hz_iss);
  assign w_set = Iss_Valid & ~Stall & (Iss_Adr != '0);

  always_comb begin
    w_pend_nxt = r_pending;
    if (WE) begin
      w_pend_nxt[WAdr] = 1'b0;
    end
    if (w_set) begin
      w_pend_nxt[Iss_Adr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          A_Valid, B_Valid, Iss_Valid;
  logic [AW-1:0] A_Adr, B_Adr, Iss_Adr, Chk1Adr, Chk2Adr;
  logic [DW-1:0] A_Din, B_Din;
  logic          A_Ready, B_Ready, WE, Stall;
  logic [AW-1:0] WAdr;
  logic [DW-1:0] Din;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_Valid(A_Valid), .A_Adr(A_Adr), .A_Din(A_Din), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Adr(B_Adr), .B_Din(B_Din), .B_Ready(B_Ready),
    .WE(WE), .WAdr(WAdr), .Din(Din),
    .Iss_Valid(Iss_Valid), .Iss_Adr(Iss_Adr),
    .Chk1Adr(Chk1Adr), .Chk2Adr(Chk2Adr), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  // Inputs change 1ns after posedge; outputs are sampled on negedge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    cyc();
    cyc();
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    A_Valid = 1'b1; A_Adr = 5'd5; A_Din = 32'h11;
    Iss_Valid = 1'b1; Iss_Adr = 5'd3; Chk1Adr = 5'd3; Chk2Adr = 5'd0;
    for (int i = 0; i < 3; i++) begin
      smp();
      checks++;
      if (WE !== 1'b0 || Stall !== 1'b0 || A_Ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d WE=%b Stall=%b A_Ready=%b required 0/0/0", i, WE, Stall, A_Ready);
      end
      cyc();
    end
    Iss_Valid = 1'b0;
    Rst_n = 1'b1;
    smp();
    checks++;
    if (A_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant A_Ready=%b required 1", A_Ready);
    end
    cyc();
    A_Valid = 1'b0;
    smp();
    checks++;
    if (WE !== 1'b1 || WAdr !== 5'd5 || Din !== 32'h11) begin
      errors++;
      $display("FAIL reset_first_write WE=%b WAdr=%0d Din=%h required 1/5/00000011", WE, WAdr, Din);
    end
    cyc();
    smp();
    checks++;
    if (WE !== 1'b0) begin
      errors++;
      $display("FAIL idle_we WE=%b required 0", WE);
    end
    cyc();
  endtask

  task automatic test_arbitration();
    logic          exp_a, exp_b;
    logic [AW-1:0] prev_adr;
    logic [DW-1:0] prev_din;
    prev_adr = '0;
    prev_din = '0;
    do_reset();
    A_Valid = 1'b1; A_Adr = 5'd3; A_Din = 32'hAAAA;
    B_Valid = 1'b1; B_Adr = 5'd4; B_Din = 32'hBBBB;
    for (int i = 0; i < 5; i++) begin
      smp();
`ifdef REGARB_FIXED_PRIO_EN
      exp_a = 1'b0;
      exp_b = 1'b1;
`else
      exp_a = (i % 2 == 0);
      exp_b = (i % 2 == 1);
`endif
      if (i < 4) begin
        checks++;
        if (A_Ready !== exp_a || B_Ready !== exp_b) begin
          errors++;
          $display("FAIL arb_grant cyc%0d A_Ready=%b B_Ready=%b required %b/%b", i, A_Ready, B_Ready, exp_a, exp_b);
        end
      end
      if (i > 0) begin
        checks++;
        if (WE !== 1'b1 || WAdr !== prev_adr || Din !== prev_din) begin
          errors++;
          $display("FAIL arb_write cyc%0d WE=%b WAdr=%0d Din=%h required 1/%0d/%h", i, WE, WAdr, Din, prev_adr, prev_din);
        end
      end
      prev_adr = exp_a ? 5'd3 : 5'd4;
      prev_din = exp_a ? 32'hAAAA : 32'hBBBB;
      cyc();
      if (i == 3) begin
        A_Valid = 1'b0;
        B_Valid = 1'b0;
      end
    end
  endtask

  task automatic test_x0();
    A_Valid = 1'b1; A_Adr = 5'd0; A_Din = 32'hFFFFFFFF;
    smp();
    checks++;
    if (A_Ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready A_Ready=%b required 1", A_Ready);
    end
    cyc();
    A_Valid = 1'b0;
    smp();
    checks++;
    if (WE !== 1'b0) begin
      errors++;
      $display("FAIL x0_we WE=%b required 0", WE);
    end
    cyc();
  endtask

  task automatic test_raw();
    Iss_Valid = 1'b1; Iss_Adr = 5'd7; Chk1Adr = 5'd0; Chk2Adr = 5'd0;
    smp();
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_issue Stall=%b required 0", Stall);
    end
    cyc();
    Iss_Adr = 5'd10; Chk1Adr = 5'd7;
    for (int i = 0; i < 2; i++) begin
      smp();
      checks++;
      if (Stall !== 1'b1) begin
        errors++;
        $display("FAIL raw_stall cyc%0d Stall=%b required 1", i, Stall);
      end
      cyc();
    end
    B_Valid = 1'b1; B_Adr = 5'd7; B_Din = 32'h77;
    smp();
    checks++;
    if (B_Ready !== 1'b1 || Stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_grant B_Ready=%b Stall=%b required 1/1", B_Ready, Stall);
    end
    cyc();
    B_Valid = 1'b0;
    smp();
    checks++;
    if (WE !== 1'b1 || WAdr !== 5'd7 || Din !== 32'h77 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_release WE=%b WAdr=%0d Din=%h Stall=%b required 1/7/00000077/0", WE, WAdr, Din, Stall);
    end
    cyc();
    Iss_Adr = 5'd11; Chk1Adr = 5'd7;
    smp();
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_cleared Stall=%b required 0", Stall);
    end
    cyc();
    Iss_Valid = 1'b0; Chk1Adr = 5'd0;
  endtask

  task automatic test_waw();
    Iss_Valid = 1'b1; Iss_Adr = 5'd9; Chk1Adr = 5'd0; Chk2Adr = 5'd0;
    cyc();
    smp();
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall Stall=%b required 1", Stall);
    end
    B_Valid = 1'b1; B_Adr = 5'd9; B_Din = 32'h99;
    cyc();
    B_Valid = 1'b0;
    smp();
    checks++;
    if (WE !== 1'b1 || WAdr !== 5'd9 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL waw_accept WE=%b WAdr=%0d Stall=%b required 1/9/0", WE, WAdr, Stall);
    end
    cyc();
    Iss_Adr = 5'd12; Chk1Adr = 5'd9;
    smp();
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_set_wins Stall=%b required 1", Stall);
    end
    cyc();
    Iss_Valid = 1'b0; Chk1Adr = 5'd0;
  endtask

  task automatic test_reset_mid();
    A_Valid = 1'b1; A_Adr = 5'd6; A_Din = 32'h66;
    cyc();
    A_Valid = 1'b0;
    checks++;
    if (WE !== 1'b1 || WAdr !== 5'd6) begin
      errors++;
      $display("FAIL mid_inflight WE=%b WAdr=%0d required 1/6", WE, WAdr);
    end
    Rst_n = 1'b0;
    #1;
    checks++;
    if (WE !== 1'b0) begin
      errors++;
      $display("FAIL mid_we_drop WE=%b required 0", WE);
    end
    cyc();
    Rst_n = 1'b1;
    Iss_Valid = 1'b1; Iss_Adr = 5'd11; Chk1Adr = 5'd9; Chk2Adr = 5'd10;
    smp();
    checks++;
    if (Stall !== 1'b0 || WE !== 1'b0) begin
      errors++;
      $display("FAIL mid_bitmap_clear Stall=%b WE=%b required 0/0", Stall, WE);
    end
    cyc();
    Iss_Valid = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0;
    A_Valid = 1'b0; A_Adr = '0; A_Din = '0;
    B_Valid = 1'b0; B_Adr = '0; B_Din = '0;
    Iss_Valid = 1'b0; Iss_Adr = '0; Chk1Adr = '0; Chk2Adr = '0;
    cyc();
    test_reset();
    test_arbitration();
    test_x0();
    test_raw();
    test_waw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE/WAdr/Din) between two writeback requesters: A = ALU/CSR pipe, B = load/memory pipe.
- Keeps a 32-entry pending-write scoreboard and raises Stall to decode for RAW and WAW hazards on reserved destinations.
- Sits between the writeback stages and the register file.
- The register file writes on the negedge of Clk, so a value driven on the write port in cycle N is readable by decode before the posedge that ends cycle N.

Parameters:
- AW, 5, register address width (32 registers).
- DW, 32, data width.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- A_Valid  in  1  requester A has a write pending.
- A_Adr  in  AW  requester A destination register.
- A_Din  in  DW  requester A write data.
- A_Ready  out  1  requester A granted this cycle (combinational).
- B_Valid  in  1  requester B has a write pending.
- B_Adr  in  AW  requester B destination register.
- B_Din  in  DW  requester B write data.
- B_Ready  out  1  requester B granted this cycle (combinational).
- WE  out  1  register file write enable (registered).
- WAdr  out  AW  register file write address (registered).
- Din  out  DW  register file write data (registered).
- Iss_Valid  in  1  decode is issuing an instruction that writes Iss_Adr.
- Iss_Adr  in  AW  destination register of the issuing instruction.
- Chk1Adr  in  AW  decode source operand 1 address.
- Chk2Adr  in  AW  decode source operand 2 address.
- Stall  out  1  decode must hold (combinational).

Behaviour:
- Reset (async, Rst_n=0):
  - WE=0, WAdr=0, Din=0.
  - Pending bitmap = 0.
  - Round-robin pointer = A.
  - A_Ready=B_Ready=0 while in reset.
- Arbitration:
  - At most one grant per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the pointer side is granted; after any grant the pointer moves to the other side.
  - Ready is high only in the cycle the transfer occurs (Valid & Ready).
  - An ungranted requester holds Valid, Adr and Din stable until granted.
- Write port:
  - Transfer in cycle N drives WE=1, WAdr=Adr, Din=data in cycle N+1 (latency 1).
  - WE=0 in any cycle following a cycle with no transfer.
- Register 0:
  - Writes to address 0 are accepted (Ready=1) but produce WE=0.
  - Pending bit 0 is never set.
- Scoreboard:
  - Set pending[Iss_Adr] on posedge when Iss_Valid & !Stall & Iss_Adr!=0.
  - Clear pending[WAdr] on posedge when WE=1.
  - Same address set and cleared on the same edge: set wins.
- Stall:
  - Stall = Iss_Valid & (hz(Chk1Adr) | hz(Chk2Adr) | hz(Iss_Adr)).
  - hz(x) = pending[x] & !(WE & WAdr==x) & x!=0.
  - The register being written this cycle is not a hazard, because the negedge write makes it readable before the posedge.
- Requester writes to an address with no pending bit are legal; they write normally and do not affect the bitmap.
- Reset asserted mid-operation: any in-flight write is dropped (WE forced to 0), the bitmap is cleared, and requesters must re-present after reset.

Optional Feature:
- Macro REGARB_FIXED_PRIO_EN.
- Defined: B (load) always wins when both are valid; the pointer register is removed.
- Undefined: round-robin as above.

Test Plan:
- Reset with A_Valid=1: WE=0, Stall=0, A_Ready=0 until Rst_n rises; A_Adr=5, A_Din=0x11 granted on the first cycle out of reset -> WE=1, WAdr=5, Din=0x11 the next cycle.
- A (x3, 0xAAAA) and B (x4, 0xBBBB) valid together for 4 cycles from reset:
  - Round-robin: grants A,B,A,B; WE sequence x3,x4,x3,x4.
  - With REGARB_FIXED_PRIO_EN: B granted every cycle, A never.
- Write to x0 with data 0xFFFFFFFF: A_Ready=1, WE stays 0, no pending change.
- Issue Iss_Adr=7, then Chk1Adr=7 next cycle:
  - Stall=1 until B writes x7.
  - In the cycle WE=1/WAdr=7, Stall=0.
  - Bitmap bit 7 cleared after that edge.
- Iss_Adr=9 pending, new Iss_Adr=9 (WAW) -> Stall=1; in the WE=1/WAdr=9 cycle the reissue is accepted and bit 9 remains set (set wins).
- Assert Rst_n=0 mid-transfer with WE=1 pending: WE drops to 0 immediately and the bitmap reads all zero after release.
